// File: rtl/ff_pkg.sv
// Shared definitions for the mode-programmable flip-flop bank.
//   mode_t  : 2-bit next-state law selector
//   MODE_*  : encodings for D, T, JK and SR behaviour
package ff_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_D  = 2'b00;
  localparam mode_t MODE_T  = 2'b01;
  localparam mode_t MODE_JK = 2'b10;
  localparam mode_t MODE_SR = 2'b11;

endpackage

// File: rtl/ff_mode_bank_if.sv
// Control/data bundle for ff_mode_bank.
//   master : drives en, mode_we, mode_in, a, b, err_clr; observes state outputs
//   slave  : the bank itself; drives q, qb, mode_q, illegal, illegal_cnt
interface ff_mode_bank_if
  import ff_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);

  logic             en;
  logic             mode_we;
  mode_t            mode_in;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             err_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qb;
  mode_t            mode_q;
  logic [WIDTH-1:0] illegal;
  logic [CNT_W-1:0] illegal_cnt;

  modport master (
    output en, mode_we, mode_in, a, b, err_clr,
    input  q, qb, mode_q, illegal, illegal_cnt
  );

  modport slave (
    input  en, mode_we, mode_in, a, b, err_clr,
    output q, qb, mode_q, illegal, illegal_cnt
  );

endinterface

// File: rtl/ff_cell.sv
// One flip-flop channel whose next-state law follows the supplied mode.
//   clk, reset  : rising-edge clock, async active-high reset (q <= RESET_VAL)
//   en          : update enable
//   mode        : D / T / JK / SR
//   a, b        : D/T/J/S and -/-/K/R inputs
//   q           : registered state
//   illegal_evt : combinational, SR with S=R=1 while enabled
module ff_cell
  import ff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  mode_t mode,
  input  logic  a,
  input  logic  b,
  output logic  q,
  output logic  illegal_evt
);

  logic r_q;
  logic w_q_next;

  // Next-state law; S=R=1 holds rather than producing an undefined value
  always_comb begin
    w_q_next = r_q;
    if (en) begin
      case (mode)
        MODE_D:  w_q_next = a;
        MODE_T:  w_q_next = a ? ~r_q : r_q;
        MODE_JK: begin
          case ({a, b})
            2'b01:   w_q_next = 1'b0;
            2'b10:   w_q_next = 1'b1;
            2'b11:   w_q_next = ~r_q;
            default: w_q_next = r_q;
          endcase
        end
        default: begin
          case ({a, b})
            2'b01:   w_q_next = 1'b0;
            2'b10:   w_q_next = 1'b1;
            default: w_q_next = r_q;
          endcase
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_q <= RESET_VAL;
    else       r_q <= w_q_next;
  end

  assign q           = r_q;
  assign illegal_evt = en & (mode == MODE_SR) & a & b;

endmodule

// File: rtl/ff_mode_bank.sv
// WIDTH-channel register bank with a run-time selectable flip-flop law,
// sticky per-channel SR-illegal flags and a saturating illegal-cycle counter.
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : slave side of ff_mode_bank_if (controls in, state out)
module ff_mode_bank
  import ff_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CNT_W     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter mode_t            MODE_RST  = MODE_D
) (
  input  logic         clk,
  input  logic         reset,
  ff_mode_bank_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  mode_t            r_mode;
  logic [WIDTH-1:0] r_illegal;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_evt;
  logic             w_any_evt;

  // Channel array; every cell sees the mode in force before any same-cycle write
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .RESET_VAL (RESET_VAL[i])
    ) u_cell (
      .clk         (clk),
      .reset       (reset),
      .en          (bus.en),
      .mode        (r_mode),
      .a           (bus.a[i]),
      .b           (bus.b[i]),
      .q           (w_q[i]),
      .illegal_evt (w_evt[i])
    );
  end

  assign w_any_evt = |w_evt;

  // Mode register
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_mode <= MODE_RST;
    else if (bus.mode_we) r_mode <= bus.mode_in;
  end

  // Sticky flags; on clear, same-cycle events replace the old flags
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            r_illegal <= '0;
    else if (bus.err_clr) r_illegal <= w_evt;
    else                  r_illegal <= r_illegal | w_evt;
  end

  // One count per cycle with any event, saturating at all-ones
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                            r_cnt <= '0;
    else if (bus.err_clr)                 r_cnt <= w_any_evt ? CNT_W'(1) : '0;
    else if (w_any_evt && r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
  end

  assign bus.q           = w_q;
  assign bus.qb          = ~w_q;
  assign bus.mode_q      = r_mode;
  assign bus.illegal     = r_illegal;
  assign bus.illegal_cnt = r_cnt;

endmodule

// File: tb/tb_ff_mode_bank.sv
// Directed self-checking bench for ff_mode_bank (WIDTH=8, CNT_W=4, RESET_VAL=A5).
module tb_ff_mode_bank;
  import ff_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_bad;

  ff_mode_bank_if #(.WIDTH(8), .CNT_W(4)) bus ();

  ff_mode_bank #(
    .WIDTH     (8),
    .CNT_W     (4),
    .RESET_VAL (8'hA5),
    .MODE_RST  (MODE_D)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mode(input mode_t m);
    bus.en      = 1'b0;
    bus.mode_we = 1'b1;
    bus.mode_in = m;
    tick();
    bus.mode_we = 1'b0;
  endtask

  task automatic drive(input logic e, input logic [7:0] va, input logic [7:0] vb, input logic clr);
    bus.en      = e;
    bus.a       = va;
    bus.b       = vb;
    bus.err_clr = clr;
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.en = 1'b0; bus.mode_we = 1'b0; bus.mode_in = MODE_D;
    bus.a = '0; bus.b = '0; bus.err_clr = 1'b0;
    #3;
    chk("rst_q",    32'(bus.q), 32'hA5);
    chk("rst_qb",   32'(bus.qb), 32'h5A);
    chk("rst_mode", 32'(bus.mode_q), 32'h0);
    chk("rst_ill",  32'(bus.illegal), 32'h0);
    chk("rst_cnt",  32'(bus.illegal_cnt), 32'h0);
    tick();
    reset = 1'b0;

    // D then T
    drive(1'b1, 8'h3C, 8'h00, 1'b0); tick();
    chk("d_q", 32'(bus.q), 32'h3C);
    chk("d_qb", 32'(bus.qb), 32'hC3);
    set_mode(MODE_T);
    chk("t_mode", 32'(bus.mode_q), 32'h1);
    chk("t_hold_en0", 32'(bus.q), 32'h3C);
    drive(1'b1, 8'hFF, 8'h00, 1'b0); tick();
    chk("t_tog1", 32'(bus.q), 32'hC3);
    tick();
    chk("t_tog2", 32'(bus.q), 32'h3C);
    drive(1'b0, 8'hFF, 8'h00, 1'b0); tick();
    chk("en0_hold", 32'(bus.q), 32'h3C);

    // Same-cycle mode write uses the old mode
    set_mode(MODE_D);
    drive(1'b1, 8'h00, 8'h00, 1'b0); tick();
    chk("d_zero", 32'(bus.q), 32'h00);
    bus.mode_we = 1'b1; bus.mode_in = MODE_T;
    drive(1'b1, 8'h01, 8'h00, 1'b0); tick();
    bus.mode_we = 1'b0;
    chk("mt_old_mode", 32'(bus.q), 32'h01);
    chk("mt_mode_q", 32'(bus.mode_q), 32'h1);
    tick();
    chk("mt_new_mode", 32'(bus.q), 32'h00);

    // JK
    set_mode(MODE_JK);
    drive(1'b1, 8'h0F, 8'h00, 1'b0); tick();
    chk("jk_set", 32'(bus.q), 32'h0F);
    drive(1'b1, 8'hF0, 8'h0F, 1'b0); tick();
    chk("jk_setrst", 32'(bus.q), 32'hF0);
    drive(1'b1, 8'hFF, 8'hFF, 1'b0); tick();
    chk("jk_toggle", 32'(bus.q), 32'h0F);
    chk("jk_no_ill", 32'(bus.illegal), 32'h0);
    chk("jk_no_cnt", 32'(bus.illegal_cnt), 32'h0);
    drive(1'b1, 8'h00, 8'h00, 1'b0); tick();
    chk("jk_hold", 32'(bus.q), 32'h0F);

    // SR and illegal handling
    set_mode(MODE_SR);
    drive(1'b0, 8'hFF, 8'hFF, 1'b0); tick();
    chk("sr_en0_ill", 32'(bus.illegal), 32'h0);
    chk("sr_en0_cnt", 32'(bus.illegal_cnt), 32'h0);
    drive(1'b1, 8'h81, 8'h81, 1'b0); tick();
    chk("sr_ill_q", 32'(bus.q), 32'h0F);
    chk("sr_ill_flags", 32'(bus.illegal), 32'h81);
    chk("sr_ill_cnt1", 32'(bus.illegal_cnt), 32'h1);
    for (int i = 0; i < 13; i++) tick();
    chk("sr_cnt14", 32'(bus.illegal_cnt), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sr_cnt_sat", 32'(bus.illegal_cnt), 32'd15);
    chk("sr_q_kept", 32'(bus.q), 32'h0F);
    drive(1'b1, 8'hF0, 8'h0F, 1'b0); tick();
    chk("sr_setrst", 32'(bus.q), 32'hF0);
    chk("sr_sticky", 32'(bus.illegal), 32'h81);

    // err_clr
    drive(1'b1, 8'h00, 8'h00, 1'b1); tick();
    chk("clr_ill", 32'(bus.illegal), 32'h0);
    chk("clr_cnt", 32'(bus.illegal_cnt), 32'h0);
    drive(1'b1, 8'h81, 8'h81, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("pre_cnt5", 32'(bus.illegal_cnt), 32'd5);
    drive(1'b1, 8'h02, 8'h02, 1'b1); tick();
    chk("clr_evt_ill", 32'(bus.illegal), 32'h02);
    chk("clr_evt_cnt", 32'(bus.illegal_cnt), 32'h1);
    chk("clr_evt_q", 32'(bus.q), 32'hF0);
    drive(1'b1, 8'h00, 8'h00, 1'b1); tick();
    chk("clr2_ill", 32'(bus.illegal), 32'h0);
    chk("clr2_cnt", 32'(bus.illegal_cnt), 32'h0);

    // Reset mid-cycle overrides pending mode write and clear
    drive(1'b1, 8'h81, 8'h81, 1'b0); tick();
    chk("pre_rst_ill", 32'(bus.illegal), 32'h81);
    bus.mode_we = 1'b1; bus.mode_in = MODE_JK;
    #2 reset = 1'b1;
    #1;
    chk("mrst_q", 32'(bus.q), 32'hA5);
    chk("mrst_qb", 32'(bus.qb), 32'h5A);
    chk("mrst_mode", 32'(bus.mode_q), 32'h0);
    chk("mrst_ill", 32'(bus.illegal), 32'h0);
    chk("mrst_cnt", 32'(bus.illegal_cnt), 32'h0);
    tick();
    chk("mrst_mode_held", 32'(bus.mode_q), 32'h0);
    chk("mrst_q_held", 32'(bus.q), 32'hA5);
    bus.mode_we = 1'b0;
    drive(1'b1, 8'h5A, 8'h00, 1'b0);
    #2 reset = 1'b0;
    tick();
    chk("post_rst_d", 32'(bus.q), 32'h5A);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ff_mode_bank.md
Name: ff_mode_bank

Overview:
- WIDTH-channel register bank. Each channel is a flip-flop whose next-state law is chosen at run time: D, T, JK or SR.
- This is the parametrised successor to the single-bit flip-flop converters. It replaces per-type hand conversions with one mode-programmable bank.
- Adds defined handling of the illegal SR input (no X propagation), per-channel sticky error flags and a saturating illegal-event counter.
- Sits wherever the sequential library needs a configurable state bank: counters, LFSR seeds, test structures.

Parameters:
- WIDTH, 8, number of flip-flop channels.
- CNT_W, 4, width of the illegal-event counter.
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset.
- MODE_RST, 2'b00, mode loaded into mode_q on reset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  update enable; when 0, q holds.
- mode_we  in  1  write strobe for the mode register.
- mode_in  in  2  new mode: 00 D, 01 T, 10 JK, 11 SR.
- a  in  WIDTH  per-channel first input: D / T / J / S.
- b  in  WIDTH  per-channel second input: unused / unused / K / R.
- err_clr  in  1  clears illegal and illegal_cnt.
- q  out  WIDTH  flip-flop state.
- qb  out  WIDTH  ~q, combinational.
- mode_q  out  2  active mode.
- illegal  out  WIDTH  sticky per-channel SR-illegal flags.
- illegal_cnt  out  CNT_W  saturating count of illegal cycles.

Behaviour:
- Reset (async, immediate, independent of clk): q=RESET_VAL, mode_q=MODE_RST, illegal=0, illegal_cnt=0, so qb=~RESET_VAL. Release takes effect at the next rising edge.
- All state updates on the rising clk edge. q latency is 1 cycle from the inputs.
- en=0: q holds regardless of a/b. No illegal detection occurs.
- en=1, per channel i, using the mode_q value current in that cycle:
  - D: q<=a[i].
  - T: q<=a[i] ? ~q : q.
  - JK: 00 hold, 01 q<=0, 10 q<=1, 11 q<=~q.
  - SR: 00 hold, 01 q<=0, 10 q<=1, 11 q holds (never X) and the illegal event fires for channel i.
- Mode register: mode_we=1 loads mode_in into mode_q at the edge. The new mode governs updates from the following cycle on. If mode_we and en occur in the same cycle, that cycle's update uses the old mode.
- Illegal event: en=1 and mode_q=SR and a[i]&b[i]=1. Only SR mode generates events; JK with 11 toggles and is legal.
  - illegal[i] sets to 1 and stays set until err_clr or reset.
  - illegal_cnt increments by 1 per cycle in which any channel has an event, not once per channel. It saturates at 2^CNT_W-1 and never wraps.
- err_clr=1 with no event that cycle: illegal<=0, illegal_cnt<=0.
- err_clr=1 together with events: the new events win. illegal<=event vector exactly (old flags dropped) and illegal_cnt<=1.
- Reset mid-operation overrides everything, including a pending mode_we or err_clr.
- No combinational path from a/b/en to q. qb and the outputs are driven directly from registers (qb through one inverter).

Decomposition:
- Shared package ff_pkg holds:
  - mode constants MODE_D=2'b00, MODE_T=2'b01, MODE_JK=2'b10, MODE_SR=2'b11;
  - a 2-bit mode type.
- Sub-module ff_cell, one channel, instantiated WIDTH times via generate:
  - inputs: clk, reset, en, mode, a, b;
  - outputs: q, illegal_evt (combinational).
  - RESET_VAL bit passed as a parameter.
- Top level owns the mode register, the sticky flags, the OR-reduction of illegal_evt and the counter.

Test Plan:
- Reset: WIDTH=8, RESET_VAL=8'hA5; assert reset mid-cycle -> q=A5 and qb=5A immediately, illegal=0, illegal_cnt=0, mode_q=00.
- D/T: mode D, en=1, a=3C -> q=3C next edge. mode_we to T, then a=FF for 2 cycles -> q=C3, then 3C. en=0 with a=FF -> q holds.
- Mode timing: q=00, mode D, same cycle mode_we=1 mode_in=T and a=01 -> q=01 (old mode applied). Next cycle a=01 -> q=00.
- JK: q=0F, a=F0 b=0F -> q=F0; then a=FF b=FF -> q=0F; then a=00 b=00 -> hold 0F.
- SR illegal: mode SR, q=0F, a=81 b=81 -> q stays 0F (bits 7,0 hold), illegal=81, cnt=1. Repeat 20 cycles with CNT_W=4 -> cnt saturates at 15.
- err_clr: cnt=5, illegal=81. err_clr with a=02 b=02 in SR -> illegal=02, cnt=1. err_clr with a=b=0 -> illegal=0, cnt=0.
